// File: rtl/cipher_dispatch_ctrl.sv
// Cipher dispatch controller: queues words tagged with the key-decoder mode and
// runs them one at a time through the encrypt (0) or decrypt (1) engine.
module cipher_dispatch_ctrl #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           active,
    input  logic           mode,
    input  logic [W-1:0]   data_in,
    input  logic           data_valid,
    output logic           data_ready,
    output logic [1:0]     eng_valid,
    output logic [W-1:0]   eng_data,
    input  logic [1:0]     eng_ready,
    input  logic [1:0]     res_valid,
    input  logic [2*W-1:0] res_data,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready,
    output logic           busy,
    output logic           timeout_err
);
    // state | meaning
    // IDLE  | no word in flight; pops the FIFO head when one is queued
    // ISSUE | request held on eng_valid until the selected engine accepts
    // WAIT  | engine working; timeout counter running down
    // OUT   | result held on out_valid/out_data until downstream takes it

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        OUT   = 4'b1000
    } state_t;

    state_t        state;
    logic [W:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [W:0]    head;
    logic          hold_mode;
    logic [TW-1:0] timer;
    logic          eng_hit;
    logic          res_hit;
    logic [W-1:0]  res_sel;

    // No bypass: a full FIFO refuses input even when the head leaves this cycle.
    assign data_ready = !reset && active && (count < CW'(DEPTH));
    assign push       = data_valid && data_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign head       = fifo_mem[rd_ptr];
    assign busy       = !reset && ((state != IDLE) || (count != '0));

    // Only the engine chosen for the held word may complete the handshakes.
    assign eng_hit = eng_ready[hold_mode];
    assign res_hit = res_valid[hold_mode];
    assign res_sel = hold_mode ? res_data[2*W-1:W] : res_data[W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {mode, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hold_mode   <= 1'b0;
            eng_valid   <= '0;
            eng_data    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            timeout_err <= 1'b0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        eng_data  <= head[W-1:0];
                        hold_mode <= head[W];
                        eng_valid <= head[W] ? 2'b10 : 2'b01;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_hit) begin
                        eng_valid <= '0;
                        timer     <= TW'(TIMEOUT - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the terminal-count cycle still wins.
                    if (res_hit) begin
                        out_data  <= res_sel;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (timer == '0) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    eng_valid <= '0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_dispatch_ctrl.sv
// Directed bench for cipher_dispatch_ctrl: a behavioural engine pair answers
// requests with the word XOR a mask after a fixed delay.
module tb_cipher_dispatch_ctrl;
    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic           clk;
    logic           reset;
    logic           active;
    logic           mode;
    logic [W-1:0]   data_in;
    logic           data_valid;
    logic           data_ready;
    logic [1:0]     eng_valid;
    logic [W-1:0]   eng_data;
    logic [1:0]     eng_ready;
    logic [1:0]     res_valid = 2'b00;
    logic [2*W-1:0] res_data  = '0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic           busy;
    logic           timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0]     resp_en;
    int             resp_delay;
    logic [7:0]     resp_mask;
    logic [1:0]     force_rv;
    logic [2*W-1:0] force_rd;
    int             cnt [2] = '{0, 0};
    logic [7:0]     lat [2];
    logic [7:0]     outq [$];
    int             engq [$];
    int             eng1_cnt = 0;

    cipher_dispatch_ctrl #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .mode        (mode),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .eng_valid   (eng_valid),
        .eng_data    (eng_data),
        .eng_ready   (eng_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // Engine model and output monitor: observe at negedge, drive results after posedge.
    always begin
        @(negedge clk);
        for (int e = 0; e < 2; e++) begin
            if (eng_valid[e] && eng_ready[e]) begin
                engq.push_back(e);
                if (resp_en[e]) begin
                    cnt[e] = resp_delay;
                    lat[e] = eng_data;
                end
            end
        end
        if (out_valid && out_ready) outq.push_back(out_data);
        if (eng_valid[1]) eng1_cnt++;
        @(posedge clk);
        #2;
        res_valid = force_rv;
        res_data  = force_rd;
        for (int e = 0; e < 2; e++) begin
            if (cnt[e] > 0) begin
                cnt[e]--;
                if (cnt[e] == 0) begin
                    res_valid[e]         = 1'b1;
                    res_data[e*W +: W]   = lat[e] ^ resp_mask;
                end
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic m);
        int n;
        n = 0;
        data_in = d;
        mode = m;
        data_valid = 1'b1;
        @(negedge clk);
        while (data_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_accept: data_ready=%b for word %h, required 1 within 100 cycles", data_ready, d);
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget);
        int k;
        k = 0;
        while (outq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; active = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (data_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_busy: data_ready=%b busy=%b, required 0 0", data_ready, busy);
        end
        vectors++;
        if (eng_valid !== 2'b00 || eng_data !== 8'h00 || out_valid !== 1'b0 ||
            out_data !== 8'h00 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: eng_valid=%b eng_data=%h out_valid=%b out_data=%h err=%b, required all 0",
                     eng_valid, eng_data, out_valid, out_data, timeout_err);
        end
        @(posedge clk); #1;
        reset = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (data_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: data_ready=%b busy=%b, required 1 0", data_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int ob;
        int e1;
        int first;
        eng_ready = 2'b11; resp_en = 2'b11; resp_delay = 2; resp_mask = 8'h66;
        ob = outq.size(); e1 = eng1_cnt;
        mode = 1'b0; data_in = 8'h3C; data_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept: data_ready=%b, required 1", data_ready);
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (eng_valid !== 2'b00 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_t1: eng_valid=%b busy=%b, required 00 1", eng_valid, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (eng_valid !== 2'b01 || eng_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL single_t2_issue: eng_valid=%b eng_data=%h, required 01 3c", eng_valid, eng_data);
        end
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && first < 0) first = k;
        end
        @(posedge clk); #1;
        vectors++;
        if (first !== 3) begin
            miscompares++;
            $display("FAIL single_out_latency: out_valid first at issue+%0d, required issue+3", first);
        end
        vectors++;
        if (outq.size() != ob + 1) begin
            miscompares++;
            $display("FAIL single_out_count: %0d outputs, required 1", outq.size() - ob);
        end else if (outq[ob] !== 8'h5A) begin
            miscompares++;
            $display("FAIL single_out_data: out_data=%h, required 5a", outq[ob]);
        end
        vectors++;
        if (eng1_cnt != e1) begin
            miscompares++;
            $display("FAIL single_eng1_idle: eng_valid[1] high %0d cycles, required 0", eng1_cnt - e1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_o [3] = '{8'hEE, 8'hDD, 8'hCC};
        int         exp_e [3] = '{0, 1, 0};
        int ob;
        int eb;
        resp_mask = 8'hFF;
        ob = outq.size(); eb = engq.size();
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        push(8'h33, 1'b0);
        wait_outs(ob + 3, 300);
        vectors++;
        if (outq.size() != ob + 3 || engq.size() != eb + 3) begin
            miscompares++;
            $display("FAIL b2b_count: outputs=%0d issues=%0d, required 3 3", outq.size() - ob, engq.size() - eb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (outq[ob+i] !== exp_o[i] || engq[eb+i] != exp_e[i]) begin
                    miscompares++;
                    $display("FAIL b2b_word%0d: out=%h engine=%0d, required %h %0d",
                             i, outq[ob+i], engq[eb+i], exp_o[i], exp_e[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] wf [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        int ob;
        int idx;
        int stuck;
        logic acc;
        eng_ready = 2'b00; resp_mask = 8'hFF;
        ob = outq.size(); idx = 0;
        mode = 1'b0; data_in = wf[0]; data_valid = 1'b1;
        for (int c = 0; c < 30 && idx < 5; c++) begin
            @(negedge clk);
            acc = data_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                data_in = wf[idx];
            end
        end
        vectors++;
        if (idx != 5) begin
            miscompares++;
            $display("FAIL full_accepts: %0d words accepted with engine stalled, required 5", idx);
        end
        stuck = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (data_ready !== 1'b0 || eng_valid !== 2'b01 || eng_data !== wf[0]) stuck++;
        end
        @(posedge clk); #1;
        vectors++;
        if (stuck != 0) begin
            miscompares++;
            $display("FAIL full_hold: %0d cycles with ready/issue wrong, required data_ready=0 eng_valid=01 eng_data=a1", stuck);
        end
        eng_ready = 2'b01;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = data_ready;
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        vectors++;
        if (acc !== 1'b1) begin
            miscompares++;
            $display("FAIL full_sixth: data_ready=%b after stall released, required 1", acc);
        end
        wait_outs(ob + 6, 400);
        vectors++;
        if (outq.size() != ob + 6) begin
            miscompares++;
            $display("FAIL full_count: %0d outputs, required 6", outq.size() - ob);
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (outq[ob+i] !== (wf[i] ^ 8'hFF)) begin
                    miscompares++;
                    $display("FAIL full_word%0d: out=%h, required %h", i, outq[ob+i], wf[i] ^ 8'hFF);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int ob;
        int c;
        int rise;
        eng_ready = 2'b11; resp_en = 2'b10; resp_mask = 8'hFF;
        ob = outq.size();
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        c = 0;
        @(negedge clk);
        while (!(eng_valid[0] && eng_ready[0]) && c < 20) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (!(eng_valid[0] && eng_ready[0])) begin
            miscompares++;
            $display("FAIL timeout_issue: eng_valid=%b, required 01 within 20 cycles", eng_valid);
        end
        @(posedge clk); #1;
        resp_en = 2'b11;
        rise = -1;
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1 && rise < 0) rise = k;
        end
        @(posedge clk); #1;
        vectors++;
        if (rise != TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout_cycle: timeout_err rose at handshake+%0d, required handshake+%0d", rise, TIMEOUT + 1);
        end
        wait_outs(ob + 1, 100);
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (outq.size() != ob + 1) begin
            miscompares++;
            $display("FAIL timeout_next_count: %0d outputs, required 1", outq.size() - ob);
        end else if (outq[ob] !== 8'h99) begin
            miscompares++;
            $display("FAIL timeout_next_data: out=%h, required 99", outq[ob]);
        end
        @(negedge clk);
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] wb [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        int ob;
        int c;
        int acc_n;
        int bad;
        logic a;
        eng_ready = 2'b11; resp_en = 2'b11; resp_mask = 8'hFF; out_ready = 1'b0;
        ob = outq.size();
        push(8'h40, 1'b0);
        c = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hBF) begin
            miscompares++;
            $display("FAIL bp_first_out: out_valid=%b out_data=%h, required 1 bf", out_valid, out_data);
        end
        @(posedge clk); #1;
        mode = 1'b0; data_in = wb[0]; data_valid = 1'b1;
        acc_n = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 8'hBF || eng_valid !== 2'b00) bad++;
            a = data_ready;
            @(posedge clk); #1;
            if (a && acc_n < 4) begin
                acc_n++;
                data_in = wb[acc_n];
            end else if (a) begin
                acc_n++;
            end
        end
        data_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_stable: %0d cycles with output moving or eng_valid high, required 0", bad);
        end
        vectors++;
        if (acc_n != DEPTH) begin
            miscompares++;
            $display("FAIL bp_fifo_fill: %0d words accepted under backpressure, required %0d", acc_n, DEPTH);
        end
        out_ready = 1'b1;
        wait_outs(ob + 5, 300);
        vectors++;
        if (outq.size() != ob + 5) begin
            miscompares++;
            $display("FAIL bp_count: %0d outputs, required 5", outq.size() - ob);
        end else begin
            vectors++;
            if (outq[ob] !== 8'hBF) begin
                miscompares++;
                $display("FAIL bp_word0: out=%h, required bf", outq[ob]);
            end
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (outq[ob+1+i] !== (wb[i] ^ 8'hFF)) begin
                    miscompares++;
                    $display("FAIL bp_word%0d: out=%h, required %h", i + 1, outq[ob+1+i], wb[i] ^ 8'hFF);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        eng_ready = 2'b11; resp_en = 2'b00; out_ready = 1'b1;
        push(8'hA0, 1'b0);
        push(8'hB0, 1'b1);
        push(8'hC0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || eng_valid !== 2'b00 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_pre: busy=%b eng_valid=%b out_valid=%b, required 1 00 0", busy, eng_valid, out_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || data_ready !== 1'b0 || eng_valid !== 2'b00 || eng_data !== 8'h00 ||
            out_valid !== 1'b0 || out_data !== 8'h00 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%b rdy=%b ev=%b ed=%h ov=%b od=%h err=%b, required all 0",
                     busy, data_ready, eng_valid, eng_data, out_valid, out_data, timeout_err);
        end
        @(posedge clk); #1;
        reset = 1'b0; active = 1'b0; data_valid = 1'b1; data_in = 8'h77;
        force_rv = 2'b01; force_rd = 16'h00AB;
        @(negedge clk);
        vectors++;
        if (data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL inactive_ready: data_ready=%b with active=0, required 0", data_ready);
        end
        @(posedge clk); #1;
        force_rv = 2'b00; force_rd = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || eng_valid !== 2'b00 || busy !== 1'b0 || data_ready !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: %0d cycles with activity after reset, required 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1; active = 1'b0; mode = 1'b0; data_in = '0; data_valid = 1'b0;
        eng_ready = 2'b00; out_ready = 1'b1;
        resp_en = 2'b00; resp_delay = 2; resp_mask = 8'h00;
        force_rv = 2'b00; force_rd = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
